mem_port_arbiter: RTL and testbench

- Shares the single ram256x8 port (MOV/MOC handshake, RW, address, typeData) between two requesters: the CPU control unit (MAR/MDR path, requester 0) and a program loader/debug port (requester 1).
- The loader replaces bench-side direct memory preloading.
- Owns the RAM-side handshake, latches each transaction, and returns MOC and read data to the granted requester.
- Adds round-robin fairness and a MOC timeout.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encoding, requester IDs,
// transfer type codes and the read/write polarity.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. On a tie the requester that did
// not win last time is chosen; the pointer itself lives in the caller.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Pick the single requester, or alternate against the last winner on a tie.
  always_comb begin
    valid = |req;
    case (req)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_LDR;
      2'b11:   winner = ~last;
      default: winner = last;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM MOV/MOC port between the CPU (requester 0) and
// the program loader (requester 1). Each granted transaction is latched into
// the ram_* registers, completion and read data are routed back to the
// winner, and a WAIT-state timeout abandons a RAM that never answers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              cpu_mov,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_type,
  output logic              cpu_moc,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_mov,
  input  logic              ldr_rw,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic [1:0]        ldr_type,
  output logic              ldr_moc,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_mov,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_type,
  input  logic              ram_moc,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              grant,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e state_q, state_d;

  logic              ram_mov_q,   ram_mov_d;
  logic              ram_rw_q,    ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        ram_type_q,  ram_type_d;
  logic              grant_q,     grant_d;
  logic              last_q,      last_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;
  logic              cpu_moc_q,   cpu_moc_d;
  logic              ldr_moc_q,   ldr_moc_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic pick_valid;
  logic pick_winner;
  logic win_mov;
  logic cnt_last;
  logic tmo_hit;

  rr_pick2 u_pick (
    .req    ({ldr_mov, cpu_mov}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign win_mov  = (grant_q == REQ_LDR) ? ldr_mov : cpu_mov;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));
  // A RAM completion on the boundary edge wins over the timeout.
  assign tmo_hit  = (state_q == ST_WAIT) && !ram_moc && cnt_last;

  // State register; CLR forces IDLE immediately.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant -> wait for RAM or timeout -> 4-phase release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_WAIT;
        else            state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (ram_moc || cnt_last) state_d = ST_DONE;
        else                     state_d = ST_WAIT;
      end
      ST_DONE: begin
        if (!win_mov) state_d = ST_IDLE;
        else          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch the winner, route completion, run the counter.
  always_comb begin
    ram_mov_d   = ram_mov_q;
    ram_rw_d    = ram_rw_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_type_d  = ram_type_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cpu_moc_d   = cpu_moc_q;
    ldr_moc_d   = ldr_moc_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_winner;
          last_d    = pick_winner;
          ram_mov_d = 1'b1;
          cnt_d     = CNT_W'(0);
          if (pick_winner == REQ_LDR) begin
            ram_rw_d    = ldr_rw;
            ram_addr_d  = ldr_addr;
            ram_wdata_d = ldr_wdata;
            ram_type_d  = ldr_type;
          end else begin
            ram_rw_d    = cpu_rw;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            ram_type_d  = cpu_type;
          end
        end else begin
          ram_mov_d = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_moc) begin
          ram_mov_d = 1'b0;
          if (grant_q == REQ_LDR) begin
            ldr_moc_d = 1'b1;
            if (ram_rw_q == RW_READ) ldr_rdata_d = ram_rdata;
            else                     ldr_rdata_d = ldr_rdata_q;
          end else begin
            cpu_moc_d = 1'b1;
            if (ram_rw_q == RW_READ) cpu_rdata_d = ram_rdata;
            else                     cpu_rdata_d = cpu_rdata_q;
          end
        end else if (cnt_last) begin
          ram_mov_d = 1'b0;
          if (grant_q == REQ_LDR) begin
            ldr_moc_d   = 1'b1;
            ldr_rdata_d = {DATA_W{1'b0}};
          end else begin
            cpu_moc_d   = 1'b1;
            cpu_rdata_d = {DATA_W{1'b0}};
          end
        end else begin
          ram_mov_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!win_mov) begin
          cpu_moc_d = 1'b0;
          ldr_moc_d = 1'b0;
        end else begin
          cpu_moc_d = cpu_moc_q;
          ldr_moc_d = ldr_moc_q;
        end
      end
      default: begin
        ram_mov_d = 1'b0;
        cpu_moc_d = 1'b0;
        ldr_moc_d = 1'b0;
      end
    endcase

    if (tmo_hit)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    busy_d = (state_d != ST_IDLE);
  end

  // Datapath registers; CLR drops ram_mov and every output at once.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ram_mov_q   <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
      ram_type_q  <= 2'b00;
      grant_q     <= REQ_CPU;
      last_q      <= REQ_LDR;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_moc_q   <= 1'b0;
      ldr_moc_q   <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
      ldr_rdata_q <= {DATA_W{1'b0}};
      cnt_q       <= CNT_W'(0);
    end else begin
      ram_mov_q   <= ram_mov_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_type_q  <= ram_type_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cpu_moc_q   <= cpu_moc_d;
      ldr_moc_q   <= ldr_moc_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_mov     = ram_mov_q;
  assign ram_rw      = ram_rw_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_type    = ram_type_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign cpu_moc     = cpu_moc_q;
  assign ldr_moc     = ldr_moc_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ldr_rdata   = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected RAM-side
// transactions and requester completions; negedge monitors pop and compare.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic          cpu_mov = 1'b0, cpu_rw = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [1:0]    cpu_type = 2'b00;
  logic          cpu_moc;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_mov = 1'b0, ldr_rw = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic [1:0]    ldr_type = 2'b00;
  logic          ldr_moc;
  logic [DW-1:0] ldr_rdata;
  logic          ram_mov, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [1:0]    ram_type;
  logic          ram_moc = 1'b0;
  logic [DW-1:0] ram_rdata;
  logic          grant, busy, err_timeout;
  logic          err_clr = 1'b0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .CLR(CLR),
    .cpu_mov(cpu_mov), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_type(cpu_type), .cpu_moc(cpu_moc), .cpu_rdata(cpu_rdata),
    .ldr_mov(ldr_mov), .ldr_rw(ldr_rw), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_type(ldr_type), .ldr_moc(ldr_moc), .ldr_rdata(ldr_rdata),
    .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_type(ram_type), .ram_moc(ram_moc), .ram_rdata(ram_rdata),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    typ;
    logic          gnt;
    int            len;    // expected ram_mov high cycles, 0 = not checked
  } ram_exp_t;

  typedef struct {
    logic          who;
    logic [DW-1:0] rdata;
    logic          err;
    int            width;  // expected moc high cycles, 0 = not checked
  } done_exp_t;

  ram_exp_t  ram_q[$];
  done_exp_t done_q[$];

  // ---------------- RAM model ----------------
  int            ram_lat   = 1;    // 0 = never completes
  logic          fixed_on  = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  int            ram_cnt   = 0;

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return {8'hA0, a, ~a, 8'h5C};
  endfunction

  always @(negedge CLK) begin
    if (ram_mov) begin
      ram_cnt = ram_cnt + 1;
      ram_moc = (ram_lat != 0) && (ram_cnt == ram_lat);
    end else begin
      ram_cnt = 0;
      ram_moc = 1'b0;
    end
  end

  assign ram_rdata = ram_moc ? (fixed_on ? fixed_val : ram_val(ram_addr)) : 32'h0BAD_0BAD;

  // ---------------- RAM-side monitor ----------------
  logic     prev_ram_mov = 1'b0;
  logic     have_ram     = 1'b0;
  logic     idle_seen    = 1'b1;
  int       ram_len      = 0;
  ram_exp_t cur_ram;

  always @(negedge CLK) begin
    if (ram_mov && !prev_ram_mov) begin
      check("idle_gap_before_grant", idle_seen, 1'b1);
      idle_seen = 1'b0;
      check("ram_q_empty_at_rise", ram_q.size() == 0, 1'b0);
      if (ram_q.size() != 0) begin
        cur_ram  = ram_q.pop_front();
        have_ram = 1'b1;
        check("ram_rw",    ram_rw,    cur_ram.rw);
        check("ram_addr",  ram_addr,  cur_ram.addr);
        check("ram_wdata", ram_wdata, cur_ram.wdata);
        check("ram_type",  ram_type,  cur_ram.typ);
        check("grant",     grant,     cur_ram.gnt);
      end
      ram_len = 0;
    end
    if (ram_mov) ram_len++;
    if (!ram_mov && prev_ram_mov && have_ram) begin
      if (cur_ram.len != 0) check("ram_mov_len", ram_len, cur_ram.len);
      have_ram = 1'b0;
    end
    if (!busy) idle_seen = 1'b1;
    prev_ram_mov = ram_mov;
  end

  // ---------------- completion monitor ----------------
  logic      prev_moc  = 1'b0;
  logic      have_done = 1'b0;
  int        moc_w     = 0;
  done_exp_t cur_done;

  always @(negedge CLK) begin
    if ((cpu_moc | ldr_moc) && !prev_moc) begin
      check("moc_both_high", cpu_moc & ldr_moc, 1'b0);
      check("done_q_empty_at_moc", done_q.size() == 0, 1'b0);
      if (done_q.size() != 0) begin
        cur_done  = done_q.pop_front();
        have_done = 1'b1;
        check("moc_owner",   ldr_moc, cur_done.who);
        check("grant_at_moc", grant,  cur_done.who);
        check("rdata", cur_done.who ? ldr_rdata : cpu_rdata, cur_done.rdata);
        check("err_timeout_at_moc", err_timeout, cur_done.err);
      end
      moc_w = 0;
    end
    if (cpu_moc | ldr_moc) moc_w++;
    if (!(cpu_moc | ldr_moc) && prev_moc && have_done) begin
      if (cur_done.width != 0) check("moc_width", moc_w, cur_done.width);
      have_done = 1'b0;
    end
    prev_moc = cpu_moc | ldr_moc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_ram(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] t, input logic g, input int len);
    ram_exp_t e;
    e.rw = rw; e.addr = a; e.wdata = d; e.typ = t; e.gnt = g; e.len = len;
    ram_q.push_back(e);
  endtask

  task automatic push_done(input logic who, input logic [DW-1:0] rd, input logic err, input int w);
    done_exp_t e;
    e.who = who; e.rdata = rd; e.err = err; e.width = w;
    done_q.push_back(e);
  endtask

  task automatic set_req(input logic who, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] t);
    if (who) begin
      ldr_rw = rw; ldr_addr = a; ldr_wdata = d; ldr_type = t; ldr_mov = 1'b1;
    end else begin
      cpu_rw = rw; cpu_addr = a; cpu_wdata = d; cpu_type = t; cpu_mov = 1'b1;
    end
  endtask

  task automatic wait_moc(input logic who);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (who ? ldr_moc : cpu_moc) begin
        ok = 1'b1;
        break;
      end
    end
    check(who ? "ldr_moc_wait_bound" : "cpu_moc_wait_bound", ok, 1'b1);
  endtask

  task automatic finish_req(input logic who);
    wait_moc(who);
    if (who) ldr_mov = 1'b0;
    else     cpu_mov = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [DW-1:0] exp_ldr_rd;

  initial begin
    // Reset state
    cyc(2);
    check("rst_ram_mov", ram_mov, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_cpu_moc", cpu_moc, 1'b0);
    check("rst_ldr_moc", ldr_moc, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ldr_rdata", ldr_rdata, 32'h0);
    check("rst_err", err_timeout, 1'b0);
    CLR = 1'b0;
    cyc(1);

    // Tie after reset: CPU first, then loader
    ram_lat = 2;
    push_ram(1'b1, 8'h30, 32'h1111_0000, TYPE_WORD, REQ_CPU, 2);
    push_ram(1'b1, 8'h40, 32'h2222_0000, TYPE_HALF, REQ_LDR, 2);
    push_done(REQ_CPU, ram_val(8'h30), 1'b0, 0);
    push_done(REQ_LDR, ram_val(8'h40), 1'b0, 0);
    set_req(REQ_CPU, 1'b1, 8'h30, 32'h1111_0000, TYPE_WORD);
    set_req(REQ_LDR, 1'b1, 8'h40, 32'h2222_0000, TYPE_HALF);
    finish_req(REQ_CPU);
    finish_req(REQ_LDR);
    cyc(2);

    // Single CPU read, RAM answers after 3 cycles
    ram_lat = 3; fixed_on = 1'b1; fixed_val = 32'hDEAD_BEEF;
    push_ram(1'b1, 8'h10, 32'h0, TYPE_WORD, REQ_CPU, 3);
    push_done(REQ_CPU, 32'hDEAD_BEEF, 1'b0, 0);
    set_req(REQ_CPU, 1'b1, 8'h10, 32'h0, TYPE_WORD);
    wait_moc(REQ_CPU);
    cpu_mov = 1'b0;
    @(negedge CLK);
    check("idle_after_drop_busy", busy, 1'b0);
    check("idle_after_drop_moc", cpu_moc, 1'b0);
    check("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    fixed_on = 1'b0;
    cyc(1);

    // Tie after a CPU win: loader first, then CPU
    ram_lat = 2;
    push_ram(1'b1, 8'h60, 32'h6666_0000, TYPE_BYTE, REQ_LDR, 2);
    push_ram(1'b1, 8'h50, 32'h5555_0000, TYPE_WORD, REQ_CPU, 2);
    push_done(REQ_LDR, ram_val(8'h60), 1'b0, 0);
    push_done(REQ_CPU, ram_val(8'h50), 1'b0, 0);
    set_req(REQ_CPU, 1'b1, 8'h50, 32'h5555_0000, TYPE_WORD);
    set_req(REQ_LDR, 1'b1, 8'h60, 32'h6666_0000, TYPE_BYTE);
    finish_req(REQ_LDR);
    finish_req(REQ_CPU);
    exp_ldr_rd = ram_val(8'h60);
    cyc(1);

    // Loader write stream: rdata must stay untouched
    ram_lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_ram(1'b0, 8'(4 * i), 32'(i + 1), TYPE_WORD, REQ_LDR, 1);
      push_done(REQ_LDR, exp_ldr_rd, 1'b0, 0);
      set_req(REQ_LDR, 1'b0, 8'(4 * i), 32'(i + 1), TYPE_WORD);
      finish_req(REQ_LDR);
    end
    check("ldr_rdata_after_writes", ldr_rdata, exp_ldr_rd);
    cyc(1);

    // Timeout: RAM never answers
    ram_lat = 0;
    push_ram(1'b1, 8'h20, 32'h0, TYPE_BYTE, REQ_CPU, TMO);
    push_done(REQ_CPU, 32'h0, 1'b1, 0);
    set_req(REQ_CPU, 1'b1, 8'h20, 32'h0, TYPE_BYTE);
    finish_req(REQ_CPU);
    check("err_sticky", err_timeout, 1'b1);
    check("cpu_rdata_after_timeout", cpu_rdata, 32'h0);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    check("err_cleared", err_timeout, 1'b0);
    cyc(1);

    // Abandon + MOC on the timeout boundary edge
    ram_lat = TMO;
    push_ram(1'b1, 8'h70, 32'h7070_7070, TYPE_HALF, REQ_CPU, TMO);
    push_done(REQ_CPU, ram_val(8'h70), 1'b0, 1);
    set_req(REQ_CPU, 1'b1, 8'h70, 32'h7070_7070, TYPE_HALF);
    cyc(4);
    cpu_mov = 1'b0;
    wait_moc(REQ_CPU);
    cyc(2);
    check("abandon_moc_low", cpu_moc, 1'b0);
    check("abandon_idle", busy, 1'b0);
    check("boundary_no_err", err_timeout, 1'b0);

    // Async reset in the middle of WAIT
    ram_lat = 0;
    push_ram(1'b1, 8'h80, 32'h8080_8080, TYPE_WORD, REQ_CPU, 0);
    set_req(REQ_CPU, 1'b1, 8'h80, 32'h8080_8080, TYPE_WORD);
    cyc(3);
    @(posedge CLK);
    #2 CLR = 1'b1;
    #1;
    check("arst_ram_mov", ram_mov, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_cpu_moc", cpu_moc, 1'b0);
    check("arst_cpu_rdata", cpu_rdata, 32'h0);
    cpu_mov = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    cyc(1);

    // First tie after reset goes to the CPU again
    ram_lat = 2;
    push_ram(1'b1, 8'h90, 32'h9090_0000, TYPE_WORD, REQ_CPU, 2);
    push_ram(1'b1, 8'hA0, 32'hA0A0_0000, TYPE_WORD, REQ_LDR, 2);
    push_done(REQ_CPU, ram_val(8'h90), 1'b0, 0);
    push_done(REQ_LDR, ram_val(8'hA0), 1'b0, 0);
    set_req(REQ_CPU, 1'b1, 8'h90, 32'h9090_0000, TYPE_WORD);
    set_req(REQ_LDR, 1'b1, 8'hA0, 32'hA0A0_0000, TYPE_WORD);
    finish_req(REQ_CPU);
    finish_req(REQ_LDR);
    cyc(3);

    check("ram_q_drained", ram_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
